// File: rtl/usbdev_in_sched_if.sv
// rtl/usbdev_in_sched_if.sv - IN protocol engine and packet-buffer read bundle for usbdev_in_sched
interface usbdev_in_sched_if #(
    parameter int NumInEps         = 12,
    parameter int MaxInPktSizeByte = 64,
    parameter int NumBuffers       = 32,
    localparam int PktW   = $clog2(MaxInPktSizeByte),
    localparam int BufIdW = $clog2(NumBuffers),
    localparam int AddrW  = BufIdW + PktW - 2
);
    logic                in_xact_starting_i;
    logic [3:0]          in_xact_start_ep_i;
    logic [3:0]          in_ep_current_i;
    logic [PktW-1:0]     in_ep_get_addr_i;
    logic                in_ep_xact_end_i;
    logic                in_ep_rollback_i;
    logic [NumInEps-1:0] in_ep_has_data_o;
    logic [NumInEps-1:0] in_ep_data_done_o;
    logic [7:0]          in_ep_data_o;
    logic                buf_rd_req_o;
    logic [AddrW-1:0]    buf_rd_addr_o;
    logic [31:0]         buf_rd_data_i;

    modport slave (
        input  in_xact_starting_i, in_xact_start_ep_i, in_ep_current_i, in_ep_get_addr_i,
        input  in_ep_xact_end_i, in_ep_rollback_i, buf_rd_data_i,
        output in_ep_has_data_o, in_ep_data_done_o, in_ep_data_o, buf_rd_req_o, buf_rd_addr_o
    );

    modport master (
        output in_xact_starting_i, in_xact_start_ep_i, in_ep_current_i, in_ep_get_addr_i,
        output in_ep_xact_end_i, in_ep_rollback_i, buf_rd_data_i,
        input  in_ep_has_data_o, in_ep_data_done_o, in_ep_data_o, buf_rd_req_o, buf_rd_addr_o
    );
endinterface

// File: rtl/usbdev_in_sched.sv
// rtl/usbdev_in_sched.sv - per-endpoint IN packet scheduler and buffer-read sequencer; option macro USBDEV_IN_SCHED_NODATA_CNT_EN
module usbdev_in_sched #(
    parameter int NumInEps         = 12,
    parameter int MaxInPktSizeByte = 64,
    parameter int NumBuffers       = 32,
    localparam int PktW   = $clog2(MaxInPktSizeByte),
    localparam int BufIdW = $clog2(NumBuffers),
    localparam int AddrW  = BufIdW + PktW - 2
) (
    input  logic                clk_48mhz_i,
    input  logic                rst_ni,
    input  logic                link_reset_i,
    input  logic                cfg_we_i,
    input  logic [3:0]          cfg_ep_i,
    input  logic [BufIdW-1:0]   cfg_buf_i,
    input  logic [PktW:0]       cfg_size_i,
    input  logic                cfg_rdy_i,
    input  logic [NumInEps-1:0] clr_rdy_i,
    output logic [NumInEps-1:0] rdy_o,
    output logic [NumInEps-1:0] sent_o,
    input  logic [NumInEps-1:0] sent_clr_i,
    output logic                sent_pulse_o,
    output logic                cfg_err_o,
`ifdef USBDEV_IN_SCHED_NODATA_CNT_EN
    input  logic                nodata_cnt_clr_i,
    output logic [15:0]         nodata_cnt_o,
`endif
    usbdev_in_sched_if.slave    eng
);
    localparam logic [PktW:0] MaxSize = (PktW+1)'(MaxInPktSizeByte);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StReady    = 2'd1,
        StInFlight = 2'd2
    } ep_state_e;

    ep_state_e           state_q [NumInEps];
    ep_state_e           state_d [NumInEps];
    logic [BufIdW-1:0]   buf_q   [NumInEps];
    logic [BufIdW-1:0]   buf_d   [NumInEps];
    logic [PktW:0]       size_q  [NumInEps];
    logic [PktW:0]       size_d  [NumInEps];
    logic [NumInEps-1:0] cancel_q, cancel_d, sent_q, sent_d;
    logic                sent_pulse_q, sent_pulse_d, cfg_err_q, cfg_err_d;
    logic                inflight_q;
    logic [1:0]          addr_lo_q;

    logic [NumInEps-1:0] cfg_hit, start_hit, cur_hit, ready_vec, inflight_vec;
    logic                cfg_ok, cur_inflight;
    logic [BufIdW-1:0]   cur_buf;

    // Per-endpoint decode of the event targets and of the current state
    always_comb begin
        for (int i = 0; i < NumInEps; i++) begin
            cfg_hit[i]      = cfg_ep_i == 4'(i);
            start_hit[i]    = eng.in_xact_starting_i && (eng.in_xact_start_ep_i == 4'(i));
            cur_hit[i]      = eng.in_ep_current_i == 4'(i);
            ready_vec[i]    = state_q[i] == StReady;
            inflight_vec[i] = state_q[i] == StInFlight;
        end
    end

    // An out-of-range endpoint never matches cfg_hit, so it is rejected too
    assign cfg_ok = cfg_we_i && (cfg_size_i <= MaxSize) && |(cfg_hit & ~inflight_vec);

    // Next-state for every endpoint plus completion / error bookkeeping
    always_comb begin
        sent_d       = sent_q;
        sent_pulse_d = 1'b0;
        cfg_err_d    = cfg_we_i && !cfg_ok;
        cancel_d     = cancel_q;
        for (int i = 0; i < NumInEps; i++) begin
            state_d[i] = state_q[i];
            buf_d[i]   = buf_q[i];
            size_d[i]  = size_q[i];
            case (state_q[i])
                StIdle, StReady: begin
                    if (cfg_ok && cfg_hit[i]) begin
                        buf_d[i]  = cfg_buf_i;
                        size_d[i] = cfg_size_i;
                        if (cfg_rdy_i) state_d[i] = StReady;
                    end
                    if (state_q[i] == StReady) begin
                        if (start_hit[i]) begin
                            state_d[i]  = StInFlight;
                            cancel_d[i] = clr_rdy_i[i];
                        end else if (clr_rdy_i[i]) begin
                            state_d[i] = StIdle;
                        end
                    end
                end
                StInFlight: begin
                    if (cur_hit[i] && eng.in_ep_xact_end_i) begin
                        state_d[i]   = StIdle;
                        cancel_d[i]  = 1'b0;
                        sent_d[i]    = 1'b1;
                        sent_pulse_d = 1'b1;
                    end else if (cur_hit[i] && eng.in_ep_rollback_i) begin
                        state_d[i]  = (cancel_q[i] || clr_rdy_i[i]) ? StIdle : StReady;
                        cancel_d[i] = 1'b0;
                    end else if (clr_rdy_i[i]) begin
                        cancel_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
        sent_d = sent_d & ~sent_clr_i;
    end

    // State and descriptor registers; bus reset clears everything like rst_ni
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni || link_reset_i) begin
            for (int i = 0; i < NumInEps; i++) begin
                state_q[i] <= StIdle;
                buf_q[i]   <= '0;
                size_q[i]  <= '0;
            end
            cancel_q     <= '0;
            sent_q       <= '0;
            sent_pulse_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            inflight_q   <= 1'b0;
            addr_lo_q    <= 2'b00;
        end else begin
            for (int i = 0; i < NumInEps; i++) begin
                state_q[i] <= state_d[i];
                buf_q[i]   <= buf_d[i];
                size_q[i]  <= size_d[i];
            end
            cancel_q     <= cancel_d;
            sent_q       <= sent_d;
            sent_pulse_q <= sent_pulse_d;
            cfg_err_q    <= cfg_err_d;
            inflight_q   <= cur_inflight;
            addr_lo_q    <= eng.in_ep_get_addr_i[1:0];
        end
    end

    // Current-endpoint view: done compare, buffer id and in-flight flag
    always_comb begin
        eng.in_ep_data_done_o = '1;
        cur_buf               = '0;
        cur_inflight          = 1'b0;
        for (int i = 0; i < NumInEps; i++) begin
            if (cur_hit[i]) begin
                eng.in_ep_data_done_o[i] = {1'b0, eng.in_ep_get_addr_i} >= size_q[i];
                cur_buf                  = buf_q[i];
                cur_inflight             = inflight_vec[i];
            end
        end
    end

    // Byte lane select uses the address registered alongside the SRAM read
    always_comb begin
        eng.in_ep_data_o = 8'h00;
        if (inflight_q) begin
            case (addr_lo_q)
                2'd0:    eng.in_ep_data_o = eng.buf_rd_data_i[7:0];
                2'd1:    eng.in_ep_data_o = eng.buf_rd_data_i[15:8];
                2'd2:    eng.in_ep_data_o = eng.buf_rd_data_i[23:16];
                default: eng.in_ep_data_o = eng.buf_rd_data_i[31:24];
            endcase
        end
    end

    assign eng.buf_rd_addr_o    = {cur_buf, eng.in_ep_get_addr_i[PktW-1:2]};
    assign eng.buf_rd_req_o     = cur_inflight;
    assign eng.in_ep_has_data_o = ready_vec | inflight_vec;
    assign rdy_o                = ready_vec | inflight_vec;
    assign sent_o               = sent_q;
    assign sent_pulse_o         = sent_pulse_q;
    assign cfg_err_o            = cfg_err_q;

`ifdef USBDEV_IN_SCHED_NODATA_CNT_EN
    logic [15:0] nodata_cnt_q;

    // Counts IN tokens that found no armed buffer; saturating, clear wins
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nodata_cnt_q <= 16'h0000;
        end else if (link_reset_i || nodata_cnt_clr_i) begin
            nodata_cnt_q <= 16'h0000;
        end else if (eng.in_xact_starting_i && !(|(start_hit & ready_vec))
                     && (nodata_cnt_q != 16'hFFFF)) begin
            nodata_cnt_q <= nodata_cnt_q + 16'd1;
        end
    end

    assign nodata_cnt_o = nodata_cnt_q;
`endif
endmodule

// File: tb/tb_usbdev_in_sched.sv
// tb/tb_usbdev_in_sched.sv - randomized scoreboard bench for usbdev_in_sched
`timescale 1ns/1ps
module tb_usbdev_in_sched;
    localparam int N   = 12;
    localparam int MAX = 64;
    localparam int NB  = 32;
    localparam int AW  = 9;

    typedef struct packed {
        logic         link_reset;
        logic         we;
        logic [3:0]   ep;
        logic [4:0]   bufid;
        logic [6:0]   size;
        logic         rdy;
        logic [N-1:0] clr;
        logic [N-1:0] sent_clr;
        logic         start;
        logic [3:0]   start_ep;
        logic [3:0]   cur;
        logic [5:0]   ga;
        logic         xend;
        logic         rb;
        logic         cnt_clr;
    } stim_t;

    typedef struct packed {
        logic [N-1:0]  rdy;
        logic [N-1:0]  sent;
        logic [N-1:0]  done;
        logic          pulse;
        logic          err;
        logic          req;
        logic          addr_chk;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [15:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stim_t        drv;
    logic [N-1:0] rdy, sent;
    logic         pulse, err;
    logic [15:0]  cnt;
    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_err = 0;

    usbdev_in_sched_if #(.NumInEps(N), .MaxInPktSizeByte(MAX), .NumBuffers(NB)) eng ();

    usbdev_in_sched #(.NumInEps(N), .MaxInPktSizeByte(MAX), .NumBuffers(NB)) dut (
        .clk_48mhz_i      (clk),
        .rst_ni           (rst_n),
        .link_reset_i     (drv.link_reset),
        .cfg_we_i         (drv.we),
        .cfg_ep_i         (drv.ep),
        .cfg_buf_i        (drv.bufid),
        .cfg_size_i       (drv.size),
        .cfg_rdy_i        (drv.rdy),
        .clr_rdy_i        (drv.clr),
        .rdy_o            (rdy),
        .sent_o           (sent),
        .sent_clr_i       (drv.sent_clr),
        .sent_pulse_o     (pulse),
        .cfg_err_o        (err),
`ifdef USBDEV_IN_SCHED_NODATA_CNT_EN
        .nodata_cnt_clr_i (drv.cnt_clr),
        .nodata_cnt_o     (cnt),
`endif
        .eng              (eng.slave)
    );

`ifndef USBDEV_IN_SCHED_NODATA_CNT_EN
    assign cnt = 16'h0000;
`endif

    // Reference model: endpoint states 0 idle, 1 ready, 2 in flight
    int           mst[N];
    int           mbuf[N];
    int           msize[N];
    bit           mcancel[N];
    logic [N-1:0] msent;
    bit           mpulse, merr, mprev_inf;
    int           mcnt, mprev_byte;
    logic [7:0]   mem[NB*MAX];

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            mst[i] = 0; mbuf[i] = 0; msize[i] = 0; mcancel[i] = 0;
        end
        msent = '0; mpulse = 0; merr = 0; mcnt = 0; mprev_inf = 0;
    endtask

    task automatic apply(input stim_t s, input logic [31:0] rd);
        drv = s;
        eng.in_xact_starting_i = s.start;
        eng.in_xact_start_ep_i = s.start_ep;
        eng.in_ep_current_i    = s.cur;
        eng.in_ep_get_addr_i   = s.ga;
        eng.in_ep_xact_end_i   = s.xend;
        eng.in_ep_rollback_i   = s.rb;
        eng.buf_rd_data_i      = rd;
    endtask

    task automatic step(input stim_t s);
        exp_t         e;
        int           cur, w, nst[N], nbyte;
        bit           cv, ok, nerr, npulse, ninf;
        logic [N-1:0] nsent;
        @(negedge clk);
        w = mprev_byte & ~3;
        apply(s, {mem[w+3], mem[w+2], mem[w+1], mem[w]});
        cur = int'(s.cur);
        cv  = cur < N;
        for (int i = 0; i < N; i++) e.rdy[i] = mst[i] != 0;
        e.sent = msent; e.pulse = mpulse; e.err = merr; e.cnt = 16'(mcnt);
        e.done = '1; e.req = 0; e.addr_chk = cv; e.addr = '0; nbyte = 0;
        if (cv) begin
            e.done[cur] = int'(s.ga) >= msize[cur];
            e.req       = mst[cur] == 2;
            e.addr      = AW'(mbuf[cur] * (MAX / 4) + int'(s.ga) / 4);
            nbyte       = mbuf[cur] * MAX + int'(s.ga);
        end
        e.data = mprev_inf ? mem[mprev_byte] : 8'h00;
        exp_q.push_back(e);
        ninf = e.req;

        if (s.link_reset) begin
            m_clear();
        end else begin
            ok = 0; nerr = 0;
            if (s.we) begin
                if (int'(s.ep) < N && int'(s.size) <= MAX && mst[s.ep] != 2) ok = 1;
                else nerr = 1;
            end
            if (s.cnt_clr) mcnt = 0;
            else if (s.start && !(int'(s.start_ep) < N && mst[s.start_ep] == 1))
                mcnt = (mcnt == 65535) ? mcnt : mcnt + 1;
            nsent = msent; npulse = 0;
            for (int i = 0; i < N; i++) begin
                nst[i] = mst[i];
                if (ok && int'(s.ep) == i) begin
                    mbuf[i] = int'(s.bufid); msize[i] = int'(s.size);
                    if (s.rdy) nst[i] = 1;
                end
                if (mst[i] == 1) begin
                    if (s.start && int'(s.start_ep) == i) nst[i] = 2;
                    else if (s.clr[i]) nst[i] = 0;
                end else if (mst[i] == 2) begin
                    if (cur == i && s.xend) begin
                        nst[i] = 0; mcancel[i] = 0; nsent[i] = 1; npulse = 1;
                    end else if (cur == i && s.rb) begin
                        nst[i] = (mcancel[i] || s.clr[i]) ? 0 : 1; mcancel[i] = 0;
                    end else if (s.clr[i]) begin
                        mcancel[i] = 1;
                    end
                end
            end
            for (int i = 0; i < N; i++) mst[i] = nst[i];
            msent = nsent & ~s.sent_clr; mpulse = npulse; merr = nerr;
        end
        mprev_inf  = s.link_reset ? 0 : ninf;
        mprev_byte = nbyte;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: outputs are stable late in the low phase, after inputs settle
    always @(negedge clk) begin
        exp_t e;
        #4;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rdy_o", 32'(rdy), 32'(e.rdy));
            chk("has_data", 32'(eng.in_ep_has_data_o), 32'(e.rdy));
            chk("sent_o", 32'(sent), 32'(e.sent));
            chk("sent_pulse_o", 32'(pulse), 32'(e.pulse));
            chk("cfg_err_o", 32'(err), 32'(e.err));
            chk("data_done", 32'(eng.in_ep_data_done_o), 32'(e.done));
            chk("buf_rd_req", 32'(eng.buf_rd_req_o), 32'(e.req));
            if (e.addr_chk) chk("buf_rd_addr", 32'(eng.buf_rd_addr_o), 32'(e.addr));
            chk("in_ep_data", 32'(eng.in_ep_data_o), 32'(e.data));
`ifdef USBDEV_IN_SCHED_NODATA_CNT_EN
            chk("nodata_cnt", 32'(cnt), 32'(e.cnt));
`endif
        end
    end

    task automatic cfg(input int ep, input int b, input int sz, input bit r);
        stim_t s = '0;
        s.we = 1; s.ep = 4'(ep); s.bufid = 5'(b); s.size = 7'(sz); s.rdy = r;
        step(s);
    endtask

    task automatic start(input int ep);
        stim_t s = '0;
        s.start = 1; s.start_ep = 4'(ep); s.cur = 4'(ep);
        step(s);
    endtask

    task automatic engine(input int ep, input int ga, input bit xe, input bit rb, input int clr_ep);
        stim_t s = '0;
        s.cur = 4'(ep); s.ga = 6'(ga); s.xend = xe; s.rb = rb;
        if (clr_ep >= 0) s.clr[clr_ep] = 1'b1;
        step(s);
    endtask

    function automatic stim_t rand_stim();
        stim_t s = '0;
        int    q[$];
        int    r;
        s.we    = $urandom_range(0, 3) == 0;
        s.ep    = 4'($urandom_range(0, 13));
        s.bufid = 5'($urandom_range(0, NB - 1));
        s.size  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(0, 64));
        s.rdy   = $urandom_range(0, 3) != 0;
        s.start = $urandom_range(0, 3) == 0;
        s.start_ep = 4'($urandom_range(0, 13));
        for (int i = 0; i < N; i++) if (mst[i] == 2) q.push_back(i);
        if (q.size() != 0 && $urandom_range(0, 3) != 0) s.cur = 4'(q[$urandom_range(0, q.size() - 1)]);
        else s.cur = 4'($urandom_range(0, 15));
        s.ga = 6'($urandom_range(0, 63));
        if (int'(s.cur) < N && mst[s.cur] == 2) begin
            r = $urandom_range(0, 9);
            s.xend = r < 2;
            s.rb   = r == 2;
        end
        if ($urandom_range(0, 9) == 0) s.clr[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 6) == 0) s.sent_clr[$urandom_range(0, N - 1)] = 1'b1;
        s.link_reset = $urandom_range(0, 149) == 0;
        s.cnt_clr    = $urandom_range(0, 39) == 0;
        if (s.start && int'(s.start_ep) < N && mst[s.start_ep] == 1) begin
            s.clr[s.start_ep] = 1'b0;
            if (s.ep == s.start_ep) s.we = 1'b0;
        end
        if (s.rb && int'(s.cur) < N) s.clr[s.cur] = 1'b0;
        return s;
    endfunction

    initial begin
        stim_t s;
        for (int i = 0; i < NB * MAX; i++) mem[i] = 8'($urandom);
        m_clear();
        mprev_byte = 0;
        apply('0, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        step('0);
        cfg(2, 5, 10, 1);
        step('0);
        start(2);
        engine(2, 6, 0, 0, -1);
        engine(2, 9, 0, 0, -1);
        engine(2, 10, 0, 0, -1);
        engine(2, 3, 1, 0, -1);
        step('0);
        s = '0; s.sent_clr[2] = 1'b1; step(s);
        cfg(2, 7, 20, 1);
        start(2);
        engine(2, 0, 0, 1, -1);
        step('0);
        start(2);
        engine(2, 19, 1, 0, -1);
        cfg(3, 9, 8, 1);
        start(3);
        engine(3, 1, 0, 0, 3);
        engine(3, 2, 0, 1, -1);
        step('0);
        cfg(3, 9, 8, 1);
        start(3);
        engine(3, 1, 0, 0, 3);
        engine(3, 2, 1, 0, -1);
        cfg(3, 1, 4, 1);
        start(3);
        cfg(3, 2, 5, 1);
        cfg(12, 2, 5, 1);
        cfg(4, 2, 65, 1);
        cfg(4, 6, 0, 1);
        engine(4, 0, 0, 0, -1);
        start(0);
        start(0);
        start(13);
        start(4);
        engine(4, 0, 0, 0, -1);
        s = '0; s.link_reset = 1'b1; s.cur = 4'd4; step(s);
        step('0);

        for (int c = 0; c < 3000; c++) step(rand_stim());
        step('0);
        @(negedge clk);
        #6;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/usbdev_in_sched.md
Name: usbdev_in_sched

Overview:
Per-endpoint IN packet scheduler and buffer-read sequencer that sits between the register interface / packet buffer SRAM and the non-buffered IN protocol engine.
- Holds software-configured IN buffer descriptors (buffer id, size, ready) for every IN endpoint.
- Presents has_data / data_done / data byte to the engine.
- Tracks each endpoint through ready → in-flight → sent/rolled-back, and reports completion to software.

Parameters:
NumInEps, 12, number of implemented IN endpoints (1..16)
MaxInPktSizeByte, 64, max packet bytes; power of 2, ≥4
NumBuffers, 32, packet buffers in SRAM
PktW, $clog2(MaxInPktSizeByte), derived; get-address width
BufIdW, $clog2(NumBuffers), derived
AddrW, BufIdW+PktW-2, derived; SRAM word address width

Ports:
clk_48mhz_i  in  1  48 MHz clock
rst_ni  in  1  async active-low reset
link_reset_i  in  1  USB bus reset; synchronous clear
cfg_we_i  in  1  write descriptor strobe
cfg_ep_i  in  4  endpoint for descriptor write
cfg_buf_i  in  BufIdW  buffer id
cfg_size_i  in  PktW+1  packet length, 0..MaxInPktSizeByte
cfg_rdy_i  in  1  mark endpoint ready with this write
clr_rdy_i  in  NumInEps  software cancel request per EP
in_xact_starting_i  in  1  engine: IN transaction starting
in_xact_start_ep_i  in  4  endpoint of starting transaction
in_ep_current_i  in  4  engine current endpoint
in_ep_get_addr_i  in  PktW  engine byte offset
in_ep_xact_end_i  in  1  engine: transaction ACKed / ISO done
in_ep_rollback_i  in  1  engine: transaction failed
in_ep_has_data_o  out  NumInEps  per-EP ready
in_ep_data_done_o  out  NumInEps  per-EP out-of-data
in_ep_data_o  out  8  byte at current get_addr
buf_rd_req_o  out  1  SRAM read enable
buf_rd_addr_o  out  AddrW  SRAM word address
buf_rd_data_i  in  32  SRAM read data; 1-cycle latency
rdy_o  out  NumInEps  ready status to registers
sent_o  out  NumInEps  sticky pkt_sent status
sent_clr_i  in  NumInEps  W1C for sent_o
sent_pulse_o  out  1  one-cycle pulse on any completion
cfg_err_o  out  1  pulse: descriptor write rejected

Behaviour:
Per-EP state: Idle, Ready, InFlight, plus a cancel_pend flag. Reset and link_reset_i put every EP in Idle, clear cancel_pend, and clear all outputs and registers to 0.

Descriptor write:
- cfg_we_i with cfg_ep_i < NumInEps and EP not InFlight → store buf/size. If cfg_rdy_i, next state is Ready.
- Write to an InFlight EP, cfg_ep_i ≥ NumInEps, or cfg_size_i > MaxInPktSizeByte → ignored, and cfg_err_o pulses the next cycle.

Transaction start:
- in_xact_starting_i for an EP in Ready → InFlight next cycle.
- For an EP in Idle → no state change.

Transaction end:
- in_ep_xact_end_i (applies to in_ep_current_i, which must be InFlight) → Idle; sent_o bit set; sent_pulse_o = 1 for one cycle.
- in_ep_rollback_i → Ready, or Idle if cancel_pend is set. sent_o is not set.

Cancel:
- clr_rdy_i in Ready → Idle.
- clr_rdy_i in InFlight → set cancel_pend; it takes effect at end/rollback and is then cleared.
- clr_rdy_i in Idle → no effect.

Simultaneous events, same EP, same cycle:
- xact_end beats clr_rdy_i.
- sent_clr_i beats the set, so sent stays clear.
- cfg_we_i in the same cycle as xact_end is rejected, because the EP is still InFlight.

Outputs:
- in_ep_has_data_o = rdy_o = (state ∈ {Ready, InFlight}), registered.
- in_ep_data_done_o[i]: for i == in_ep_current_i, (in_ep_get_addr_i ≥ size[i]), compared at PktW+1 bits; all other bits are 1. Size 0 gives done immediately; size = MaxInPktSizeByte is never done via the compare.

Buffer read:
- buf_rd_addr_o = buf[current]*(MaxInPktSizeByte/4) + get_addr[PktW-1:2], combinational.
- buf_rd_req_o = 1 whenever the current EP is InFlight.
- in_ep_data_o = byte get_addr[1:0] of buf_rd_data_i, selected with a registered copy of get_addr[1:0]. It is valid 1 cycle after get_addr is presented.
- Outside InFlight, in_ep_data_o = 0.

Optional Feature:
USBDEV_IN_SCHED_NODATA_CNT_EN:
- When defined: adds output nodata_cnt_o[15:0] and input nodata_cnt_clr_i. The counter increments on in_xact_starting_i for an EP not Ready, saturates at 16'hFFFF, and is cleared by reset, link_reset_i, or nodata_cnt_clr_i. Clear wins over increment.
- When undefined: both ports are absent and there is no counter logic.

Test Plan:
- Write EP2 buf=5, size=10, rdy → rdy_o[2]=1 next cycle; in_xact_starting_i ep2 → InFlight; get_addr=6 → buf_rd_addr_o=5*16+1=81; data_done[2]=0 at get_addr 9, =1 at get_addr 10.
- EP2 InFlight, in_ep_xact_end_i → rdy_o[2]=0, sent_o[2]=1, sent_pulse_o single-cycle; sent_clr_i[2] → sent_o[2]=0.
- EP2 InFlight, in_ep_rollback_i → rdy_o[2] stays 1, sent_o[2]=0; new start then xact_end completes normally.
- EP3 InFlight, clr_rdy_i[3], then rollback → EP3 Idle, rdy_o[3]=0, no sent; with xact_end instead → sent_o[3]=1.
- cfg_we_i to InFlight EP3, to ep 12, or size 65 → cfg_err_o pulse, descriptors unchanged; size 0 with rdy → data_done=1 at get_addr 0.
- link_reset_i mid-InFlight → all rdy_o/sent_o=0, counter=0 (with USBDEV_IN_SCHED_NODATA_CNT_EN: 3 starts to Idle EP → nodata_cnt_o=3).
